// File: rtl/stream_sequencer_if.sv
// Handshake bundle between the stream sequencer and the HPS sampler/player pair.
// The sequencer takes the master view; the HPS side (or a bench) takes the slave view.
interface stream_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             sampler_active;
  logic             player_active;
  logic             play_enable;
  logic [WIDTH-1:0] play_data;
  logic [WIDTH-1:0] sample_data;

  modport master (
    input  sampler_active,
    input  player_active,
    input  play_data,
    output play_enable,
    output sample_data
  );

  modport slave (
    output sampler_active,
    output player_active,
    output play_data,
    input  play_enable,
    input  sample_data
  );
endinterface

// File: rtl/stream_sequencer.sv
// Sequences one HPS sampler/player run: start delay, bounded or unbounded word
// counting, stall fault detection and a registered sample-data mux.
module stream_sequencer #(
  parameter int WIDTH     = 32,
  parameter int COUNT_W   = 24,
  parameter int STALL_MAX = 255
) (
  input  logic                clk,
  input  logic                reset,
  stream_sequencer_if.master  hps,
  input  logic [15:0]         cfg_delay,
  input  logic [COUNT_W-1:0]  cfg_length,
  input  logic                cfg_loopback,
  input  logic [WIDTH-1:0]    ext_data,
  output logic                busy,
  output logic                done,
  output logic                fault,
  output logic [COUNT_W-1:0]  word_count,
  output logic [2:0]          state,
  output logic [3:0]          led
);

  localparam int STALL_W = (STALL_MAX > 1) ? $clog2(STALL_MAX + 1) : 1;
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX - 1);
  localparam logic [STALL_W-1:0] STALL_ONE  = STALL_W'(1);
  localparam logic [COUNT_W-1:0] COUNT_ONE  = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] COUNT_ZERO = {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0] COUNT_FULL = {COUNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DELAY = 3'd1,
    ST_RUN   = 3'd2,
    ST_FAULT = 3'd3
  } state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic                 sampler_prev_r;
  logic [15:0]          delay_cnt_r;
  logic [15:0]          delay_next_s;
  logic [COUNT_W-1:0]   length_r;
  logic [COUNT_W-1:0]   length_next_s;
  logic [COUNT_W-1:0]   word_count_r;
  logic [COUNT_W-1:0]   count_next_s;
  logic [STALL_W-1:0]   stall_cnt_r;
  logic [STALL_W-1:0]   stall_next_s;
  logic                 done_r;
  logic                 done_next_s;
  logic                 done_seen_r;
  logic                 done_seen_next_s;
  logic                 play_enable_r;
  logic [WIDTH-1:0]     sample_data_r;
  logic                 busy_r;
  logic                 fault_r;
  logic                 run_r;

  logic                 start_s;
  logic [COUNT_W-1:0]   word_inc_s;
  logic                 len_hit_s;
  logic                 stall_hit_s;

  // Start is a registered rising edge; the previous-value flop resets high so a
  // level that is already up when reset releases does not start a run.
  assign start_s     = hps.sampler_active & ~sampler_prev_r;
  assign word_inc_s  = (word_count_r == COUNT_FULL) ? word_count_r : (word_count_r + COUNT_ONE);
  assign len_hit_s   = (length_r != COUNT_ZERO) && (word_inc_s == length_r);
  assign stall_hit_s = (stall_cnt_r == STALL_LAST);

  // Next-state and datapath-next logic for the run sequencer.
  always_comb begin
    state_next_s     = state_r;
    delay_next_s     = delay_cnt_r;
    length_next_s    = length_r;
    count_next_s     = word_count_r;
    stall_next_s     = stall_cnt_r;
    done_next_s      = 1'b0;
    done_seen_next_s = done_seen_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          delay_next_s     = cfg_delay;
          length_next_s    = cfg_length;
          count_next_s     = COUNT_ZERO;
          stall_next_s     = {STALL_W{1'b0}};
          done_seen_next_s = 1'b0;
          if (cfg_delay != 16'd0) begin
            state_next_s = ST_DELAY;
          end else begin
            state_next_s = ST_RUN;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_DELAY: begin
        if (!hps.sampler_active) begin
          state_next_s = ST_IDLE;
        end else if (delay_cnt_r == 16'd1) begin
          state_next_s = ST_RUN;
          delay_next_s = 16'd0;
        end else begin
          delay_next_s = delay_cnt_r - 16'd1;
        end
      end
      ST_RUN: begin
        // Completion outranks an abort on the same cycle; an abort holds the count.
        if (hps.player_active && len_hit_s) begin
          count_next_s     = length_r;
          done_next_s      = 1'b1;
          done_seen_next_s = 1'b1;
          state_next_s     = ST_IDLE;
        end else if (!hps.sampler_active) begin
          state_next_s = ST_IDLE;
        end else if (hps.player_active) begin
          count_next_s = word_inc_s;
          stall_next_s = {STALL_W{1'b0}};
        end else if (stall_hit_s) begin
          stall_next_s = stall_cnt_r + STALL_ONE;
          state_next_s = ST_FAULT;
        end else begin
          stall_next_s = stall_cnt_r + STALL_ONE;
        end
      end
      ST_FAULT: begin
        if (!hps.sampler_active) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_FAULT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      sampler_prev_r <= 1'b1;
      delay_cnt_r    <= 16'd0;
      length_r       <= COUNT_ZERO;
      word_count_r   <= COUNT_ZERO;
      stall_cnt_r    <= {STALL_W{1'b0}};
      done_r         <= 1'b0;
      done_seen_r    <= 1'b0;
      play_enable_r  <= 1'b0;
      sample_data_r  <= {WIDTH{1'b0}};
      busy_r         <= 1'b0;
      fault_r        <= 1'b0;
      run_r          <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      sampler_prev_r <= hps.sampler_active;
      delay_cnt_r    <= delay_next_s;
      length_r       <= length_next_s;
      word_count_r   <= count_next_s;
      stall_cnt_r    <= stall_next_s;
      done_r         <= done_next_s;
      done_seen_r    <= done_seen_next_s;
      // Enable rises one cycle into RUN but drops on the same edge RUN is left.
      play_enable_r  <= (state_r == ST_RUN) && (state_next_s == ST_RUN);
      if (state_r == ST_RUN) begin
        sample_data_r <= cfg_loopback ? hps.play_data : ext_data;
      end else begin
        sample_data_r <= {WIDTH{1'b0}};
      end
      busy_r         <= (state_next_s != ST_IDLE);
      fault_r        <= (state_next_s == ST_FAULT);
      run_r          <= (state_next_s == ST_RUN);
    end
  end

  assign hps.play_enable = play_enable_r;
  assign hps.sample_data = sample_data_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign fault           = fault_r;
  assign word_count      = word_count_r;
  assign state           = state_r;
  assign led             = {fault_r, done_seen_r, run_r, busy_r};

endmodule

// File: tb/tb_stream_sequencer.sv
// Directed bench for stream_sequencer: stimulus queues cycle-tagged expectations
// and done events; a negedge monitor pops and compares them.
module tb_stream_sequencer;
  localparam int WIDTH   = 32;
  localparam int COUNT_W = 24;

  localparam int S_STATE = 0;
  localparam int S_PE    = 1;
  localparam int S_SDATA = 2;
  localparam int S_BUSY  = 3;
  localparam int S_DONE  = 4;
  localparam int S_FAULT = 5;
  localparam int S_WC    = 6;
  localparam int S_LED   = 7;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset;
  logic [15:0]        cfg_delay;
  logic [COUNT_W-1:0] cfg_length;
  logic               cfg_loopback;
  logic [WIDTH-1:0]   ext_data;
  logic               busy;
  logic               done;
  logic               fault;
  logic [COUNT_W-1:0] word_count;
  logic [2:0]         state;
  logic [3:0]         led;

  exp_t        exp_q[$];
  logic [31:0] done_q[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  logic        drain = 1'b0;
  logic        drained = 1'b0;
  logic [31:0] mon_act;
  logic [31:0] mon_wc;

  stream_sequencer_if #(.WIDTH(WIDTH)) hps();

  stream_sequencer #(.WIDTH(WIDTH), .COUNT_W(COUNT_W), .STALL_MAX(255)) dut (
    .clk          (clk),
    .reset        (reset),
    .hps          (hps),
    .cfg_delay    (cfg_delay),
    .cfg_length   (cfg_length),
    .cfg_loopback (cfg_loopback),
    .ext_data     (ext_data),
    .busy         (busy),
    .done         (done),
    .fault        (fault),
    .word_count   (word_count),
    .state        (state),
    .led          (led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] get_sig(int sig);
    case (sig)
      S_STATE: return {29'd0, state};
      S_PE:    return {31'd0, hps.play_enable};
      S_SDATA: return hps.sample_data;
      S_BUSY:  return {31'd0, busy};
      S_DONE:  return {31'd0, done};
      S_FAULT: return {31'd0, fault};
      S_WC:    return {8'd0, word_count};
      S_LED:   return {28'd0, led};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int dc, input int sig, input logic [31:0] val, input string name);
    exp_t e;
    e.cyc  = cyc + dc;
    e.sig  = sig;
    e.val  = val;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic expect_reset(input int dc, input string tag);
    expect_at(dc, S_STATE, 32'd0, {tag, "_state"});
    expect_at(dc, S_PE,    32'd0, {tag, "_play_enable"});
    expect_at(dc, S_SDATA, 32'd0, {tag, "_sample_data"});
    expect_at(dc, S_BUSY,  32'd0, {tag, "_busy"});
    expect_at(dc, S_DONE,  32'd0, {tag, "_done"});
    expect_at(dc, S_FAULT, 32'd0, {tag, "_fault"});
    expect_at(dc, S_WC,    32'd0, {tag, "_word_count"});
    expect_at(dc, S_LED,   32'd0, {tag, "_led"});
  endtask

  // Monitor: timed expectations, done events, and a final drain check.
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        mon_act = get_sig(exp_q[i].sig);
        n_vec++;
        if (mon_act !== exp_q[i].val) begin
          n_bad++;
          $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", exp_q[i].name, mon_act, exp_q[i].val, cyc);
        end
        exp_q.delete(i);
      end
    end
    if (done === 1'b1) begin
      n_vec++;
      if (done_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_done: got done=1 with word_count %0d, want no done (cycle %0d)", word_count, cyc);
      end else begin
        mon_wc = done_q.pop_front();
        if ({8'd0, word_count} !== mon_wc) begin
          n_bad++;
          $display("FAIL done_word_count: got %0d, want %0d (cycle %0d)", word_count, mon_wc, cyc);
        end
      end
    end
    if (drain && !drained) begin
      n_vec++;
      if (exp_q.size() != 0) begin
        n_bad++;
        $display("FAIL unchecked_expectations: got %0d left, want 0", exp_q.size());
      end
      n_vec++;
      if (done_q.size() != 0) begin
        n_bad++;
        $display("FAIL missing_done: got %0d pending, want 0", done_q.size());
      end
      drained = 1'b1;
    end
  end

  initial begin
    reset = 1'b1;
    hps.sampler_active = 1'b0;
    hps.player_active  = 1'b0;
    hps.play_data      = 32'd0;
    cfg_delay    = 16'd0;
    cfg_length   = 24'd0;
    cfg_loopback = 1'b0;
    ext_data     = 32'd0;
    repeat (3) tick();
    expect_reset(0, "rst");
    reset = 1'b0;
    repeat (2) tick();

    // Delay 3, length 10: enable 4 cycles after the start edge, done after 10 words.
    cfg_delay = 16'd3;
    cfg_length = 24'd10;
    hps.player_active = 1'b1;
    hps.sampler_active = 1'b1;
    expect_at(1,  S_STATE, 32'd1, "t1_delay_state");
    expect_at(1,  S_BUSY,  32'd1, "t1_busy");
    expect_at(4,  S_STATE, 32'd2, "t1_run_state");
    expect_at(4,  S_PE,    32'd0, "t1_pe_not_yet");
    expect_at(5,  S_PE,    32'd1, "t1_pe_rise");
    expect_at(9,  S_WC,    32'd5, "t1_wc_mid");
    expect_at(13, S_PE,    32'd1, "t1_pe_last");
    expect_at(13, S_LED,   32'h3, "t1_led_run");
    expect_at(14, S_DONE,  32'd1, "t1_done");
    expect_at(14, S_WC,    32'd10, "t1_wc_final");
    expect_at(14, S_STATE, 32'd0, "t1_idle");
    expect_at(14, S_PE,    32'd0, "t1_pe_low");
    expect_at(14, S_LED,   32'h4, "t1_led_done");
    expect_at(15, S_DONE,  32'd0, "t1_done_pulse");
    expect_at(20, S_STATE, 32'd0, "t1_no_level_restart");
    expect_at(21, S_LED,   32'h4, "t1_done_seen_sticky");
    done_q.push_back(32'd10);
    repeat (22) tick();
    hps.sampler_active = 1'b0;
    repeat (2) tick();

    // Unbounded run of 1000 words with loopback mux checks, then abort.
    cfg_delay = 16'd0;
    cfg_length = 24'd0;
    cfg_loopback = 1'b1;
    hps.play_data = 32'hDEADBEEF;
    ext_data = 32'h12345678;
    hps.sampler_active = 1'b1;
    expect_at(1, S_STATE, 32'd2, "t2_run_state");
    expect_at(1, S_PE,    32'd0, "t2_pe_not_yet");
    expect_at(2, S_PE,    32'd1, "t2_pe_rise");
    expect_at(1, S_SDATA, 32'd0, "t2_sdata_idle");
    expect_at(2, S_SDATA, 32'hDEADBEEF, "t2_sdata_loop");
    expect_at(2, S_LED,   32'h3, "t2_led_run");
    repeat (5) tick();
    expect_at(0, S_SDATA, 32'hDEADBEEF, "t2_sdata_loop_hold");
    cfg_loopback = 1'b0;
    hps.play_data = 32'hCAFEF00D;
    expect_at(1, S_SDATA, 32'h12345678, "t2_sdata_ext");
    repeat (996) tick();
    expect_at(0, S_WC, 32'd1000, "t2_wc_1000");
    hps.sampler_active = 1'b0;
    expect_at(1, S_STATE, 32'd0, "t2_abort_idle");
    expect_at(1, S_WC,    32'd1000, "t2_wc_held");
    expect_at(1, S_PE,    32'd0, "t2_pe_low");
    expect_at(1, S_DONE,  32'd0, "t2_no_done");
    expect_at(2, S_SDATA, 32'd0, "t2_sdata_zero");
    expect_at(2, S_LED,   32'h0, "t2_led_idle");
    repeat (3) tick();

    // Player stalled for 255 RUN cycles -> FAULT, held until sampler drops.
    hps.player_active = 1'b0;
    hps.sampler_active = 1'b1;
    expect_at(255, S_STATE, 32'd2, "t3_still_run");
    expect_at(255, S_PE,    32'd1, "t3_pe_before_fault");
    expect_at(256, S_STATE, 32'd3, "t3_fault_state");
    expect_at(256, S_FAULT, 32'd1, "t3_fault");
    expect_at(256, S_PE,    32'd0, "t3_pe_fault");
    expect_at(256, S_LED,   32'h9, "t3_led_fault");
    repeat (260) tick();
    hps.player_active = 1'b1;
    expect_at(3, S_STATE, 32'd3, "t3_fault_held");
    expect_at(3, S_WC,    32'd0, "t3_no_count_in_fault");
    repeat (4) tick();
    hps.sampler_active = 1'b0;
    expect_at(1, S_STATE, 32'd0, "t3_exit_idle");
    expect_at(1, S_FAULT, 32'd0, "t3_fault_clear");
    repeat (2) tick();
    hps.player_active = 1'b0;
    hps.sampler_active = 1'b1;
    expect_at(1, S_STATE, 32'd2, "t3_restart");
    repeat (2) tick();
    hps.sampler_active = 1'b0;
    repeat (2) tick();

    // Length 5 with sampler falling on the completing cycle: done still pulses.
    cfg_length = 24'd5;
    hps.player_active = 1'b1;
    hps.sampler_active = 1'b1;
    expect_at(5, S_WC,    32'd4, "t4_wc_4");
    expect_at(6, S_DONE,  32'd1, "t4_done");
    expect_at(6, S_WC,    32'd5, "t4_wc_5");
    expect_at(6, S_STATE, 32'd0, "t4_idle");
    expect_at(6, S_LED,   32'h4, "t4_led");
    expect_at(7, S_DONE,  32'd0, "t4_done_pulse");
    done_q.push_back(32'd5);
    repeat (5) tick();
    hps.sampler_active = 1'b0;
    repeat (4) tick();

    // Reset mid-RUN with sampler held high: no restart until a fresh edge.
    cfg_length = 24'd0;
    hps.sampler_active = 1'b1;
    repeat (10) tick();
    expect_at(0, S_STATE, 32'd2, "t5_running");
    expect_at(0, S_WC,    32'd9, "t5_wc_9");
    expect_at(0, S_SDATA, 32'h12345678, "t5_sdata_ext");
    reset = 1'b1;
    expect_reset(1, "t5_rst");
    tick();
    reset = 1'b0;
    expect_at(5, S_STATE, 32'd0, "t5_no_restart");
    expect_at(5, S_PE,    32'd0, "t5_pe_low");
    expect_at(5, S_SDATA, 32'd0, "t5_sdata_zero");
    repeat (6) tick();
    hps.sampler_active = 1'b0;
    tick();
    hps.sampler_active = 1'b1;
    expect_at(1, S_STATE, 32'd2, "t5_restart");
    expect_at(1, S_WC,    32'd0, "t5_wc_cleared");
    repeat (3) tick();
    hps.sampler_active = 1'b0;
    repeat (3) tick();

    drain = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
